// File: rtl/ex_mdu_pkg.sv
// Shared constants, state encoding and operand-class helpers for the RV32M
// iterative multiply/divide unit.
package ex_mdu_pkg;

   localparam logic [6:0] FUNC7_M = 7'b0000001;

   localparam logic [2:0] INST_MUL    = 3'd0;
   localparam logic [2:0] INST_MULH   = 3'd1;
   localparam logic [2:0] INST_MULHSU = 3'd2;
   localparam logic [2:0] INST_MULHU  = 3'd3;
   localparam logic [2:0] INST_DIV    = 3'd4;
   localparam logic [2:0] INST_DIVU   = 3'd5;
   localparam logic [2:0] INST_REM    = 3'd6;
   localparam logic [2:0] INST_REMU   = 3'd7;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } mdu_state_e;

   function automatic logic op1_is_signed(input logic [2:0] f);
      return (f == INST_MULH) || (f == INST_MULHSU) || (f == INST_DIV) || (f == INST_REM);
   endfunction

   function automatic logic op2_is_signed(input logic [2:0] f);
      return (f == INST_MULH) || (f == INST_DIV) || (f == INST_REM);
   endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// Request/response bundle between the execute stage (master) and the MDU (slave).
interface ex_mdu_if #(
   parameter int unsigned XLEN = 32
);
   logic            start_i;
   logic [2:0]      func3_i;
   logic [XLEN-1:0] op1_i;
   logic [XLEN-1:0] op2_i;
   logic [4:0]      rd_addr_i;
   logic            flush_i;
   logic            busy_o;
   logic            hold_flag_o;
   logic [XLEN-1:0] rd_data_o;
   logic [4:0]      rd_addr_o;
   logic            rd_wen_o;

   modport master (
      output start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
      input  busy_o, hold_flag_o, rd_data_o, rd_addr_o, rd_wen_o
   );

   modport slave (
      input  start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
      output busy_o, hold_flag_o, rd_data_o, rd_addr_o, rd_wen_o
   );
endinterface

// File: rtl/ex_mdu.sv
// Iterative radix-2 RV32M multiply/divide unit: unsigned magnitudes are processed
// in a shared 2*XLEN accumulator and the sign is restored when the result is written.
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter  int unsigned XLEN  = 32,
   localparam int unsigned CNT_W = $clog2(XLEN + 1)
) (
   input logic      clk,
   input logic      rst_n,
   ex_mdu_if.slave  mdu_io
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

   mdu_state_e        state_q;
   logic [2:0]        func3_q;
   logic [4:0]        addr_q;
   logic              neg_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   opb_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   rd_data_q;
   logic [4:0]        rd_addr_q;
   logic              rd_wen_q;

   // Start-cycle decode
   logic              s1, s2;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_zero, div_ovf, early;
   logic [XLEN-1:0]   early_res;
   logic              neg_d;

   always_comb begin
      s1        = op1_is_signed(mdu_io.func3_i) & mdu_io.op1_i[XLEN-1];
      s2        = op2_is_signed(mdu_io.func3_i) & mdu_io.op2_i[XLEN-1];
      mag1      = s1 ? -mdu_io.op1_i : mdu_io.op1_i;
      mag2      = s2 ? -mdu_io.op2_i : mdu_io.op2_i;
      div_zero  = (mdu_io.op2_i == '0);
      div_ovf   = ((mdu_io.func3_i == INST_DIV) || (mdu_io.func3_i == INST_REM)) &&
                  (mdu_io.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_io.op2_i == '1);
      early     = mdu_io.func3_i[2] & (div_zero | div_ovf);
      early_res = '0;
      if (div_zero) begin
         early_res = mdu_io.func3_i[1] ? mdu_io.op1_i : '1;
      end else if (div_ovf) begin
         early_res = mdu_io.func3_i[1] ? '0 : mdu_io.op1_i;
      end
      // Remainder takes the dividend's sign; product and quotient take s1^s2.
      neg_d = (mdu_io.func3_i[2] && mdu_io.func3_i[1]) ? s1 : (s1 ^ s2);
   end

   // One radix-2 step plus the signed result it would produce on the final step
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;
   logic [XLEN-1:0]   result;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      div_diff = rem_sh - {1'b0, opb_q};
      if (func3_q[2]) begin
         // A clear top bit of the difference means the divisor fits: quotient bit 1.
         acc_step = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end
      prod_fix = neg_q ? -acc_step : acc_step;
      quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      result   = '0;
      case (func3_q)
         INST_MUL:                           result = prod_fix[XLEN-1:0];
         INST_MULH, INST_MULHSU, INST_MULHU: result = prod_fix[2*XLEN-1:XLEN];
         INST_DIV, INST_DIVU:                result = quo_fix;
         default:                            result = rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         func3_q   <= '0;
         addr_q    <= '0;
         neg_q     <= 1'b0;
         cnt_q     <= '0;
         opb_q     <= '0;
         acc_q     <= '0;
         rd_data_q <= '0;
         rd_addr_q <= '0;
         rd_wen_q  <= 1'b0;
      end else begin
         rd_wen_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (mdu_io.start_i && !mdu_io.flush_i) begin
                  func3_q <= mdu_io.func3_i;
                  addr_q  <= mdu_io.rd_addr_i;
                  neg_q   <= neg_d;
                  cnt_q   <= '0;
                  if (early) begin
                     rd_data_q <= early_res;
                     rd_addr_q <= mdu_io.rd_addr_i;
                     rd_wen_q  <= 1'b1;
                     state_q   <= StDone;
                  end else begin
                     // Divide: dividend in the low half. Multiply: multiplier there.
                     acc_q   <= {{XLEN{1'b0}}, (mdu_io.func3_i[2] ? mag1 : mag2)};
                     opb_q   <= mdu_io.func3_i[2] ? mag2 : mag1;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               if (mdu_io.flush_i) begin
                  state_q <= StIdle;
               end else begin
                  acc_q <= acc_step;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CntLast) begin
                     rd_data_q <= result;
                     rd_addr_q <= addr_q;
                     rd_wen_q  <= 1'b1;
                     state_q   <= StDone;
                  end
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mdu_io.busy_o      = (state_q != StIdle);
   assign mdu_io.hold_flag_o = ((state_q == StIdle) & mdu_io.start_i & ~mdu_io.flush_i) |
                               (state_q == StCalc);
   assign mdu_io.rd_data_o   = rd_data_q;
   assign mdu_io.rd_addr_o   = rd_addr_q;
   assign mdu_io.rd_wen_o    = rd_wen_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed vector table, random ops against a
// plain-arithmetic RV32M model, and flush/reset/back-to-back sequences.
module tb_ex_mdu;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ex_mdu_if #(.XLEN(32)) mdu_if ();

   ex_mdu #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mdu_io (mdu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sa;
      int          sb;
      sa = int'(a);
      sb = int'(b);
      case (f)
         3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
         3'd1: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
         3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); return sp[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f[2] && b == 32'd0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issue one op and follow it to its write strobe (bounded).
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, output int lat, output int holds,
                        output logic [31:0] data, output logic [4:0] waddr,
                        output bit timeout);
      lat     = 0;
      holds   = 0;
      data    = '0;
      waddr   = '0;
      timeout = 1'b0;
      @(posedge clk); #1;
      mdu_if.start_i   = 1'b1;
      mdu_if.func3_i   = f3;
      mdu_if.op1_i     = a;
      mdu_if.op2_i     = b;
      mdu_if.rd_addr_i = addr;
      #1;
      if (mdu_if.hold_flag_o) holds++;
      @(posedge clk); #1;
      mdu_if.start_i = 1'b0;
      mdu_if.op1_i   = $urandom;
      mdu_if.op2_i   = $urandom;
      while (1) begin
         lat++;
         if (mdu_if.rd_wen_o) begin
            data  = mdu_if.rd_data_o;
            waddr = mdu_if.rd_addr_o;
            break;
         end
         if (mdu_if.hold_flag_o) holds++;
         if (lat >= 40) begin
            timeout = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   vec_t        vecs[12];
   int          lat, holds, nwr;
   logic [31:0] data;
   logic [4:0]  waddr;
   bit          to, wen_seen;

   initial begin
      checks = 0;
      errors = 0;
      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
      vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

      rst_n            = 1'b0;
      mdu_if.start_i   = 1'b0;
      mdu_if.flush_i   = 1'b0;
      mdu_if.func3_i   = '0;
      mdu_if.op1_i     = '0;
      mdu_if.op2_i     = '0;
      mdu_if.rd_addr_i = '0;
      #12;
      check("reset busy", mdu_if.busy_o, 0);
      check("reset hold", mdu_if.hold_flag_o, 0);
      check("reset wen", mdu_if.rd_wen_o, 0);
      check("reset data", mdu_if.rd_data_o, 0);
      check("reset addr", mdu_if.rd_addr_o, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), lat, holds, data, waddr, to);
         check($sformatf("vec%0d timeout", i), to, 0);
         check($sformatf("vec%0d data", i), data, vecs[i].exp);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d hold cycles", i), holds, vecs[i].lat);
         check($sformatf("vec%0d addr", i), waddr, 5'(i + 1));
         @(posedge clk); #1;
         check($sformatf("vec%0d wen drop", i), mdu_if.rd_wen_o, 0);
         check($sformatf("vec%0d data kept", i), mdu_if.rd_data_o, vecs[i].exp);
      end

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f;
         logic [31:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 20));
            3: a = 32'($urandom_range(0, 100));
            default: ;
         endcase
         do_op(f, a, b, 5'($urandom), lat, holds, data, waddr, to);
         check($sformatf("rnd%0d f%0d %0h,%0h data", i, f, a, b), data, ref_mdu(f, a, b));
         check($sformatf("rnd%0d latency", i), lat, ref_lat(f, a, b));
      end

      // Flush during CALC cycle 10
      @(posedge clk); #1;
      mdu_if.start_i = 1'b1; mdu_if.func3_i = 3'd0; mdu_if.op1_i = 32'd3; mdu_if.op2_i = 32'd5;
      mdu_if.rd_addr_i = 5'd9;
      @(posedge clk); #1;
      mdu_if.start_i = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      check("flush busy before", mdu_if.busy_o, 1);
      mdu_if.flush_i = 1'b1;
      @(posedge clk); #1;
      mdu_if.flush_i = 1'b0;
      check("flush busy after", mdu_if.busy_o, 0);
      check("flush hold after", mdu_if.hold_flag_o, 0);
      wen_seen = 1'b0;
      repeat (35) begin @(posedge clk); #1; if (mdu_if.rd_wen_o) wen_seen = 1'b1; end
      check("flush no write", wen_seen, 0);
      do_op(3'd5, 32'd100, 32'd7, 5'd4, lat, holds, data, waddr, to);
      check("post-flush data", data, 32'd14);
      check("post-flush latency", lat, 33);

      // Flush in IDLE suppresses start
      @(posedge clk); #1;
      mdu_if.start_i = 1'b1; mdu_if.flush_i = 1'b1; mdu_if.func3_i = 3'd5;
      mdu_if.op1_i = 32'd1; mdu_if.op2_i = 32'd1;
      #1;
      check("idle flush hold", mdu_if.hold_flag_o, 0);
      @(posedge clk); #1;
      mdu_if.start_i = 1'b0; mdu_if.flush_i = 1'b0;
      check("idle flush busy", mdu_if.busy_o, 0);

      // Flush in DONE is ignored
      @(posedge clk); #1;
      mdu_if.start_i = 1'b1; mdu_if.func3_i = 3'd5; mdu_if.op1_i = 32'd5; mdu_if.op2_i = 32'd0;
      mdu_if.rd_addr_i = 5'd3;
      @(posedge clk); #1;
      mdu_if.start_i = 1'b0; mdu_if.flush_i = 1'b1;
      check("done flush wen", mdu_if.rd_wen_o, 1);
      check("done flush data", mdu_if.rd_data_o, 32'hFFFF_FFFF);
      check("done flush addr", mdu_if.rd_addr_o, 5'd3);
      @(posedge clk); #1;
      mdu_if.flush_i = 1'b0;
      check("done flush idle", mdu_if.busy_o, 0);

      // start_i held high: DIVU 9/3 every 34 cycles
      @(posedge clk); #1;
      mdu_if.start_i = 1'b1; mdu_if.func3_i = 3'd5; mdu_if.op1_i = 32'd9; mdu_if.op2_i = 32'd3;
      mdu_if.rd_addr_i = 5'd7;
      nwr = 0;
      for (int c = 1; c <= 105; c++) begin
         @(posedge clk); #1;
         if (mdu_if.rd_wen_o) begin
            check($sformatf("b2b%0d cycle", nwr), c, 33 + 34 * nwr);
            check($sformatf("b2b%0d data", nwr), mdu_if.rd_data_o, 32'd3);
            check($sformatf("b2b%0d hold", nwr), mdu_if.hold_flag_o, 0);
            nwr++;
         end
      end
      mdu_if.start_i = 1'b0;
      check("b2b count", nwr, 3);

      // Asynchronous reset mid-CALC
      check("pre-reset busy", mdu_if.busy_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset busy", mdu_if.busy_o, 0);
      check("midreset hold", mdu_if.hold_flag_o, 0);
      check("midreset wen", mdu_if.rd_wen_o, 0);
      check("midreset data", mdu_if.rd_data_o, 0);
      check("midreset addr", mdu_if.rd_addr_o, 0);
      #10;
      rst_n = 1'b1;
      wen_seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (mdu_if.rd_wen_o) wen_seen = 1'b1; end
      check("post-reset no write", wen_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
